// File: rtl/sumres_display_pkg.sv
// Shared types and constants for the add/subtract display unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, segment constants, and a digit-to-segment lookup.
package sumres_display_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Latency: WIDTH+1 shift cycles after the start cycle; bcd is final the cycle after done.
// Backpressure: none; start restarts the conversion unconditionally.
// Ports: clk, reset (sync, active-high), start (load bin, clear accumulator),
//        bin[WIDTH:0] value to convert, bcd result nibbles (units in [3:0]),
//        done high during the cycle whose clock edge performs the final shift.
module bin2bcd_seq #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH:0]            bin,
  output logic [4*(NDIG-1)-1:0]     bcd,
  output logic                      done
);

  localparam int BCDW = 4 * (NDIG - 1);
  localparam int CW   = $clog2(WIDTH + 1);

  logic [WIDTH:0] sh;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic [BCDW-1:0] adj;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG - 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // cnt counts completed shifts, so the shift performed while cnt==WIDTH is the last.
  assign done = busy && (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      bcd <= {adj[BCDW-2:0], sh[WIDTH]};
      sh  <= sh << 1;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sumres_display_nd.sv
// Add/subtract unit showing a signed-magnitude decimal result on a multiplexed 7-seg display.
// Latency: a new result is committed every WIDTH+3 cycles (LOAD, WIDTH+1 x SHIFT, COMMIT).
// Backpressure: none; FSM and digit scan are free-running.
// Ports: clk, reset (sync, active-high), sel (0 add, 1 subtract), a/b unsigned operands,
//        SSeg active-low segments {g,f,e,d,c,b,a}, an active-low digit enables (an[0] = units),
//        conv_done one-cycle pulse when the display register takes a new result.
module sumres_display_nd
  import sumres_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [6:0]       SSeg,
  output logic [NDIG-1:0]  an,
  output logic             conv_done
);

  localparam int BCDW = 4 * (NDIG - 1);
  localparam int IW   = $clog2(NDIG);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam logic [NDIG-1:0] AN_ONE = {{(NDIG-1){1'b0}}, 1'b1};

  state_t          state;
  logic [WIDTH:0]  mag;
  logic            neg;
  logic            neg_q;
  logic            start;
  logic            cvt_done;
  logic [BCDW-1:0] bcd;
  logic [BCDW-1:0] disp_bcd;
  logic            disp_neg;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [IW-1:0]   scan_idx;
  logic [6:0]      digit_seg;

  // Signed-magnitude result; equal operands under subtract give +0.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    if (!sel) begin
      mag = {1'b0, a} + {1'b0, b};
    end else if (a >= b) begin
      mag = {1'b0, a - b};
    end else begin
      mag = {1'b0, b - a};
      neg = 1'b1;
    end
  end

  // The converter latches mag on the same edge that leaves LOAD.
  assign start = (state == ST_LOAD);

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (mag),
    .bcd   (bcd),
    .done  (cvt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      neg_q     <= 1'b0;
      disp_bcd  <= '0;
      disp_neg  <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        ST_LOAD: begin
          neg_q <= neg;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cvt_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_bcd  <= bcd;
          disp_neg  <= neg_q;
          conv_done <= 1'b1;
          state     <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign tick = (div_cnt == DW'(SCAN_DIV - 1));

  // Segment pattern for the digit about to be scanned. A middle digit is
  // blanked when it and all digits above it are zero; units is always shown.
  always_comb begin
    digit_seg = SEG_BLANK;
    for (int i = 0; i < NDIG - 1; i++) begin
      if (scan_idx == IW'(i) && (i == 0 || (disp_bcd >> (4 * i)) != '0))
        digit_seg = seg_lut(disp_bcd[4*i +: 4]);
    end
    if (scan_idx == IW'(NDIG - 1) && disp_neg) digit_seg = SEG_MINUS;
  end

  // Scan reads disp_bcd before any same-edge commit, so a new result shows from the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      an       <= '1;
      SSeg     <= SEG_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        an       <= ~(AN_ONE << scan_idx);
        SSeg     <= digit_seg;
        scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + IW'(1);
      end
    end
  end

  for (genvar g = 0; g < NDIG - 1; g++) begin : g_bcd_chk
    a_digit_range : assert property (@(posedge clk) disable iff (reset)
      disp_bcd[4*g +: 4] <= 4'd9);
  end

endmodule

// File: tb/tb_sumres_display_nd.sv
module tb_sumres_display_nd;

  localparam int WIDTH    = 8;
  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [6:0]       SSeg;
  logic [NDIG-1:0]  an;
  logic             conv_done;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] cap  [NDIG];
  bit         seen [NDIG];

  sumres_display_nd #(
    .WIDTH    (WIDTH),
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .SSeg      (SSeg),
    .an        (an),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  // Reference: what digit idx should show for operands ra/rb under rsel.
  function automatic logic [6:0] model_seg(input int ra, input int rb, input bit rsel, input int idx);
    int mag;
    bit neg;
    int p;
    int d;
    logic [6:0] s;
    if (!rsel)        begin mag = ra + rb; neg = 1'b0; end
    else if (ra >= rb) begin mag = ra - rb; neg = 1'b0; end
    else               begin mag = rb - ra; neg = 1'b1; end
    if (idx == NDIG - 1) return neg ? 7'b0111111 : 7'h7F;
    p = 1;
    for (int j = 0; j < idx; j++) p = p * 10;
    if (idx != 0 && mag < p) return 7'h7F;
    d = (mag / p) % 10;
    case (d)
      0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;
      3: s = 7'b0110000;  4: s = 7'b0011001;  5: s = 7'b0010010;
      6: s = 7'b0000010;  7: s = 7'b1111000;  8: s = 7'b0000000;
      default: s = 7'b0010000;
    endcase
    return s;
  endfunction

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!conv_done && n < 40);
    if (!conv_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no conv_done within %0d cycles (expected a pulse every 11)", tag, n);
    end
  endtask

  // Skip one scan slot so every captured value was loaded after the latest commit.
  task automatic capture();
    for (int i = 0; i < NDIG; i++) begin cap[i] = 7'h00; seen[i] = 1'b0; end
    repeat (4) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDIG; i++) begin
        if (an == ~(4'b0001 << i)) begin cap[i] = SSeg; seen[i] = 1'b1; end
      end
    end
  endtask

  task automatic settle_and_capture(input string tag);
    int n;
    wait_done(tag, n);
    wait_done(tag, n);
    capture();
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (an !== 4'b1111 || SSeg !== 7'h7F || conv_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: an=%b SSeg=%h done=%b, want 1111/7f/0", an, SSeg, conv_done);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (conv_done !== (k == 11)) begin
        miscompares++;
        $display("FAIL reset_done_timing: cycle %0d conv_done=%b want %b", k, conv_done, (k == 11));
      end
      if (k < 4) begin
        vectors++;
        if (an !== 4'b1111 || SSeg !== 7'h7F) begin
          miscompares++;
          $display("FAIL reset_pre_tick: cycle %0d an=%b SSeg=%h want 1111/7f", k, an, SSeg);
        end
      end else if (k == 4) begin
        vectors++;
        if (an !== 4'b1110 || SSeg !== 7'b1000000) begin
          miscompares++;
          $display("FAIL reset_first_tick: an=%b SSeg=%b want 1110/1000000", an, SSeg);
        end
      end
    end
  endtask

  task automatic test_add_max();
    logic [3:0] prev;
    logic [3:0] exp_an;
    int n;
    a = 8'd200; b = 8'd255; sel = 1'b0;
    settle_and_capture("add_max");
    for (int i = 0; i < NDIG; i++) begin
      vectors++;
      if (!seen[i] || cap[i] !== model_seg(200, 255, 1'b0, i)) begin
        miscompares++;
        $display("FAIL add_max_digit%0d: seen=%0d SSeg=%b want %b", i, seen[i], cap[i], model_seg(200, 255, 1'b0, i));
      end
    end
    n = 0;
    do begin
      prev = an;
      @(negedge clk);
      n++;
    end while (!(an == 4'b1110 && prev != 4'b1110) && n < 40);
    for (int c = 0; c < 20; c++) begin
      exp_an = ~(4'b0001 << ((c / 4) % 4));
      vectors++;
      if (an !== exp_an) begin
        miscompares++;
        $display("FAIL scan_order: step %0d an=%b want %b", c, an, exp_an);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sub_neg();
    a = 8'd3; b = 8'd10; sel = 1'b1;
    settle_and_capture("sub_neg");
    for (int i = 0; i < NDIG; i++) begin
      vectors++;
      if (!seen[i] || cap[i] !== model_seg(3, 10, 1'b1, i)) begin
        miscompares++;
        $display("FAIL sub_neg_digit%0d: seen=%0d SSeg=%b want %b", i, seen[i], cap[i], model_seg(3, 10, 1'b1, i));
      end
    end
  endtask

  task automatic test_zero();
    a = 8'd0; b = 8'd0; sel = 1'b1;
    settle_and_capture("zero");
    for (int i = 0; i < NDIG; i++) begin
      vectors++;
      if (!seen[i] || cap[i] !== model_seg(0, 0, 1'b1, i)) begin
        miscompares++;
        $display("FAIL zero_digit%0d: seen=%0d SSeg=%b want %b", i, seen[i], cap[i], model_seg(0, 0, 1'b1, i));
      end
    end
  endtask

  task automatic test_random();
    int ra, rb, n;
    bit rs;
    for (int t = 0; t < 15; t++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rs = 1'($urandom_range(0, 1));
      if (t == 0) begin ra = 255; rb = 255; rs = 1'b0; end
      if (t == 1) begin ra = 0; rb = 255; rs = 1'b1; end
      if (t == 2) begin ra = 77; rb = 77; rs = 1'b1; end
      a = 8'(ra); b = 8'(rb); sel = rs;
      wait_done("rand", n);
      wait_done("rand", n);
      vectors++;
      if (n !== 11) begin
        miscompares++;
        $display("FAIL rand_period: %0d cycles between conv_done, want 11", n);
      end
      capture();
      for (int i = 0; i < NDIG; i++) begin
        vectors++;
        if (!seen[i] || cap[i] !== model_seg(ra, rb, rs, i)) begin
          miscompares++;
          $display("FAIL rand_digit%0d a=%0d b=%0d sel=%0d: SSeg=%b want %b", i, ra, rb, rs, cap[i], model_seg(ra, rb, rs, i));
        end
      end
    end
  endtask

  task automatic test_midconv_change();
    int rb;
    rb = $urandom_range(0, 255);
    a = 8'd10; b = 8'(rb); sel = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 3) a = 8'd99;
      vectors++;
      if (conv_done !== (k == 11 || k == 22)) begin
        miscompares++;
        $display("FAIL midconv_done: cycle %0d conv_done=%b want %b", k, conv_done, (k == 11 || k == 22));
      end
      if (k == 20) begin
        vectors++;
        if (an !== 4'b1110 || SSeg !== model_seg(10, rb, 1'b0, 0)) begin
          miscompares++;
          $display("FAIL midconv_old: an=%b SSeg=%b want 1110/%b", an, SSeg, model_seg(10, rb, 1'b0, 0));
        end
      end
      if (k == 24) begin
        vectors++;
        if (an !== 4'b1101 || SSeg !== model_seg(99, rb, 1'b0, 1)) begin
          miscompares++;
          $display("FAIL midconv_new: an=%b SSeg=%b want 1101/%b", an, SSeg, model_seg(99, rb, 1'b0, 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    a = 8'd123; b = 8'd45; sel = 1'b1;
    wait_done("reset_mid", n);
    wait_done("reset_mid", n);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (an !== 4'b1111 || SSeg !== 7'h7F || conv_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_hold: an=%b SSeg=%h done=%b want 1111/7f/0", an, SSeg, conv_done);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (conv_done !== (k == 11)) begin
        miscompares++;
        $display("FAIL reset_mid_done: cycle %0d conv_done=%b want %b", k, conv_done, (k == 11));
      end
      if (k < 4) begin
        vectors++;
        if (an !== 4'b1111 || SSeg !== 7'h7F) begin
          miscompares++;
          $display("FAIL reset_mid_pre_tick: cycle %0d an=%b SSeg=%h want 1111/7f", k, an, SSeg);
        end
      end else if (k == 4) begin
        vectors++;
        if (an !== 4'b1110 || SSeg !== 7'b1000000) begin
          miscompares++;
          $display("FAIL reset_mid_cleared: an=%b SSeg=%b want 1110/1000000", an, SSeg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_max();
    test_sub_neg();
    test_zero();
    test_random();
    test_midconv_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
